// File: rtl/sim_crg_top.sv
`timescale 1ns/1ps
// sim_crg_top
// Behavioural stand-in for a PLL-plus-clock-divider reset/clock generator.
// After reset release it waits for an emulated PLL lock, briefly stops the
// gated clocks, realigns the /2 divider, and then runs forever. Nothing here
// depends on a global set/reset; every register has an explicit async reset.
//
// Ports
//   clkin    : in  - 100 MHz reference, the only clock
//   rst_n    : in  - asynchronous active-low reset
//   sync2x   : out - gated copy of clkin (edge clock)
//   sync     : out - clkin/2, rising edges aligned to sync2x rising edges
//   dramsync : out - sync, enabled only once the sequence reaches RUN
//   init     : out - free-running clkin/4
module sim_crg_top #(
  parameter int LOCK_CYCLES = 32,
  parameter int STOP_CYCLES = 4
) (
  input  logic clkin,
  input  logic rst_n,
  output logic sync2x,
  output logic sync,
  output logic dramsync,
  output logic init
);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STOP,
    UPDATE,
    RESUME,
    RUN
  } state_t;

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CYCLES - 1);
  localparam logic [7:0] STOP_LAST = 8'(STOP_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic       clk_open;   // divider running and edge clock ungated
  logic       dram_req;   // sequence finished, DRAM clock may start
  logic       en;
  logic       dram_en;
  logic       sync_div;
  logic [1:0] init_cnt;

  // State register; the cycle counter restarts on every state change.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        cnt <= '0;
      else if (state != RUN)
        cnt <= cnt + 8'd1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_LOCK: if (cnt == LOCK_LAST) state_next = STOP;
      STOP:      if (cnt == STOP_LAST) state_next = UPDATE;
      UPDATE:    if (cnt == STOP_LAST) state_next = RESUME;
      RESUME:    if (cnt == STOP_LAST) state_next = RUN;
      RUN:       state_next = RUN;
      default:   state_next = WAIT_LOCK;
    endcase
  end

  // Output decode.
  always_comb begin
    clk_open = 1'b1;
    dram_req = 1'b0;
    case (state)
      STOP, UPDATE: clk_open = 1'b0;
      RUN:          dram_req = 1'b1;
      default:      clk_open = 1'b1;
    endcase
  end

  // Divider is held at 0 while stopped so that its first rising edge after
  // RESUME lands on the first ungated sync2x edge.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n)
      sync_div <= 1'b0;
    else if (!clk_open)
      sync_div <= 1'b0;
    else
      sync_div <= ~sync_div;
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n)
      init_cnt <= '0;
    else
      init_cnt <= init_cnt + 2'd1;
  end

  // Enables update on the falling edge, while clkin is low, so the AND gates
  // below can never clip a high phase.
  always_ff @(negedge clkin or negedge rst_n) begin
    if (!rst_n)
      en <= 1'b0;
    else
      en <= clk_open;
  end

  // dram_en may only rise while sync is low, so dramsync starts on a full
  // sync high phase.
  always_ff @(negedge clkin or negedge rst_n) begin
    if (!rst_n)
      dram_en <= 1'b0;
    else if (dram_req && !sync_div)
      dram_en <= 1'b1;
  end

  // rst_n in the gate drops sync2x immediately on reset, without a clock edge.
  assign sync2x   = clkin & en & rst_n;
  assign sync     = sync_div;
  assign dramsync = sync_div & dram_en;
  assign init     = init_cnt[1];

endmodule

// File: tb/tb_sim_crg_top.sv
`timescale 1ns/1ps
// Self-checking bench for sim_crg_top. The expected waveforms are derived
// from the edge index n since reset release (n = 1 on the first rising edge).
module tb_sim_crg_top;

  localparam int L = 32;
  localparam int S = 4;

  logic clkin = 1'b0;
  logic rst_n = 1'b1;
  logic sync2x;
  logic sync;
  logic dramsync;
  logic init;

  int checks   = 0;
  int failures = 0;
  int n        = 0;
  bit neg_seen = 1'b0;
  bit dram_flag = 1'b0;

  sim_crg_top #(.LOCK_CYCLES(L), .STOP_CYCLES(S)) dut (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .sync2x   (sync2x),
    .sync     (sync),
    .dramsync (dramsync),
    .init     (init)
  );

  initial forever #5 clkin = ~clkin;

  // sync level after rising edge k: toggles on edges 1..L, held low through
  // STOP and UPDATE, then toggles again starting with edge L+2S+1.
  function automatic bit sync_model(int k);
    if (k <= L)
      return (k % 2) == 1;
    else if (k <= L + 2 * S)
      return 1'b0;
    else
      return ((k - (L + 2 * S)) % 2) == 1;
  endfunction

  task automatic chk(string nm, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s n=%0d t=%0t: got %b expected %b", nm, n, $time, got, exp);
    end
  endtask

  // Compare process.
  initial begin
    logic pc;
    bit   s_e, i_e, x_e, d_e;
    bit   s_last, i_last, d_last;
    pc = clkin;
    s_last = 0; i_last = 0; d_last = 0;
    forever begin
      @(clkin or rst_n);
      if (clkin !== pc) begin
        pc = clkin;
        if (clkin) begin
          if (!rst_n) begin
            n = 0; neg_seen = 0; dram_flag = 0;
          end else begin
            n++;
          end
          #1;
          if (n == 0) begin
            chk("rst_sync2x", sync2x, 1'b0);
            chk("rst_sync", sync, 1'b0);
            chk("rst_dramsync", dramsync, 1'b0);
            chk("rst_init", init, 1'b0);
            s_last = 0; i_last = 0; d_last = 0;
          end else begin
            s_e = sync_model(n);
            i_e = (n % 4) >= 2;
            x_e = (n == 1) ? neg_seen : !(n >= L + 1 && n <= L + 2 * S);
            d_e = s_e && dram_flag;
            chk("sync", sync, s_e);
            chk("init", init, i_e);
            chk("sync2x_hi", sync2x, x_e);
            chk("dramsync", dramsync, d_e);
            if (n >= L + 3 * S && !s_e) dram_flag = 1'b1;
            s_last = s_e; i_last = i_e; d_last = d_e;
            case (n)
              2:  chk("pin_init_e2", init, 1'b1);
              32: begin chk("pin_sync_e32", sync, 1'b0); chk("pin_sync2x_e32", sync2x, 1'b1); end
              33: chk("pin_sync2x_e33", sync2x, 1'b0);
              40: chk("pin_sync2x_e40", sync2x, 1'b0);
              41: begin chk("pin_sync_e41", sync, 1'b1); chk("pin_sync2x_e41", sync2x, 1'b1); end
              44: chk("pin_dramsync_e44", dramsync, 1'b0);
              45: chk("pin_dramsync_e45", dramsync, 1'b1);
              default: ;
            endcase
          end
        end else begin
          if (rst_n && n == 0) neg_seen = 1'b1;
          if (!rst_n) begin s_last = 0; i_last = 0; d_last = 0; end
          #1;
          chk("sync2x_lo", sync2x, 1'b0);
          chk("sync_lo", sync, s_last);
          chk("init_lo", init, i_last);
          chk("dramsync_lo", dramsync, d_last);
        end
      end else if (!rst_n) begin
        // Reset just asserted: everything must already be low.
        #0.5;
        chk("async_sync2x", sync2x, 1'b0);
        chk("async_sync", sync, 1'b0);
        chk("async_dramsync", dramsync, 1'b0);
        chk("async_init", init, 1'b0);
      end
    end
  end

  // Stimulus: randomized release phase, run length and reset hold time.
  initial begin
    int run_len;
    #1 rst_n = 1'b0;
    #49;
    for (int seg = 0; seg < 6; seg++) begin
      if ($urandom_range(0, 1) == 1) @(posedge clkin);
      else @(negedge clkin);
      #($urandom_range(2, 4));
      rst_n = 1'b1;
      if (seg == 0)      run_len = 195;
      else if (seg == 1) run_len = $urandom_range(60, 200);
      else               run_len = $urandom_range(5, 120);
      repeat (run_len) @(posedge clkin);
      #($urandom_range(2, 4));
      rst_n = 1'b0;
      repeat ($urandom_range(3, 8)) @(posedge clkin);
    end
    @(negedge clkin);
    #2 rst_n = 1'b1;
    repeat (60) @(posedge clkin);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
